// File: rtl/control_sequencer_if.sv
// Handshake bundle between the SAP-1 ring counter/IR and the controller-sequencer.
// The slave modport is the sequencer's view; master is the ring counter / datapath view.
interface control_sequencer_if #(
  parameter int ICOUNT_W = 8
);
  logic [5:0]          state;
  logic [3:0]          opcode;
  logic [11:0]         con;
  logic                hlt;
  logic                illegal_op;
  logic                seq_err;
  logic [ICOUNT_W-1:0] icount;

  modport master (
    output state, opcode,
    input  con, hlt, illegal_op, seq_err, icount
  );

  modport slave (
    input  state, opcode,
    output con, hlt, illegal_op, seq_err, icount
  );
endinterface

// File: rtl/control_sequencer.sv
// SAP-1 controller-sequencer: decodes T-state/opcode into the 12-bit control word and
// holds halt, illegal-opcode, retired-count state. Ring checker present when CTRL_SEQ_CHECK_EN is defined.
module control_sequencer #(
  parameter int ICOUNT_W = 8
) (
  input  logic                CLK,
  input  logic                CLR,
  control_sequencer_if.slave  bus
);

  localparam logic [3:0]  OP_LDA = 4'b0000;
  localparam logic [3:0]  OP_ADD = 4'b0001;
  localparam logic [3:0]  OP_SUB = 4'b0010;
  localparam logic [3:0]  OP_OUT = 4'b1110;
  localparam logic [3:0]  OP_HLT = 4'b1111;

  localparam logic [5:0]  T1 = 6'b000001;
  localparam logic [5:0]  T2 = 6'b000010;
  localparam logic [5:0]  T3 = 6'b000100;
  localparam logic [5:0]  T4 = 6'b001000;
  localparam logic [5:0]  T5 = 6'b010000;
  localparam logic [5:0]  T6 = 6'b100000;

  localparam logic [11:0] NOP = 12'h3E3;

  logic                hlt_q;
  logic                illegal_q;
  logic [ICOUNT_W-1:0] icount_q;

  function automatic logic is_defined(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_OUT) || (op == OP_HLT);
  endfunction

  // Exact one-hot matching: any zero or multi-bit state falls to the NOP default.
  function automatic logic [11:0] decode(input logic [5:0] st, input logic [3:0] op,
                                         input logic halted);
    logic [11:0] w;
    w = NOP;
    if (!halted) begin
      case (st)
        T1: w = 12'h5E3;
        T2: w = 12'hBE3;
        T3: w = 12'h263;
        T4: begin
          if (op == OP_LDA || op == OP_ADD || op == OP_SUB) w = 12'h1A3;
          else if (op == OP_OUT)                            w = 12'h3F2;
        end
        T5: begin
          if (op == OP_LDA)                      w = 12'h2C3;
          else if (op == OP_ADD || op == OP_SUB) w = 12'h2E1;
        end
        T6: begin
          if (op == OP_ADD)      w = 12'h3C7;
          else if (op == OP_SUB) w = 12'h3CF;
        end
        default: w = NOP;
      endcase
    end
    return w;
  endfunction

  assign bus.con        = decode(bus.state, bus.opcode, hlt_q);
  assign bus.hlt        = hlt_q;
  assign bus.illegal_op = illegal_q;
  assign bus.icount     = icount_q;

  // HLT and an undefined opcode cannot coincide, so the two T4 updates never conflict.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      hlt_q     <= 1'b0;
      illegal_q <= 1'b0;
      icount_q  <= '0;
    end else begin
      if (bus.state == T4 && bus.opcode == OP_HLT)
        hlt_q <= 1'b1;
      if (bus.state == T4 && !is_defined(bus.opcode) && !hlt_q)
        illegal_q <= 1'b1;
      if (bus.state == T6 && !hlt_q)
        icount_q <= icount_q + 1'b1;
    end
  end

`ifdef CTRL_SEQ_CHECK_EN
  logic [5:0] expected_q;
  logic       seq_err_q;

  // Expected phase advances every edge regardless of mismatch or halt.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      expected_q <= T1;
      seq_err_q  <= 1'b0;
    end else begin
      if (bus.state != expected_q)
        seq_err_q <= 1'b1;
      expected_q <= {expected_q[4:0], expected_q[5]};
    end
  end

  assign bus.seq_err = seq_err_q;
`else
  assign bus.seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: decode table, directed multi-cycle sequences and
// randomized ring traffic checked against a micro-operation level reference model.
module tb_control_sequencer;

`ifdef CTRL_SEQ_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  // Control signal positions in the word; active-low ones are inverted at assembly.
  localparam logic [11:0] S_CP = 12'h800, S_EP = 12'h400, S_LM = 12'h200, S_CE = 12'h100;
  localparam logic [11:0] S_LI = 12'h080, S_EI = 12'h040, S_LA = 12'h020, S_EA = 12'h010;
  localparam logic [11:0] S_SU = 12'h008, S_EU = 12'h004, S_LB = 12'h002, S_LO = 12'h001;
  localparam logic [11:0] ACTIVE_LOW = S_LM | S_CE | S_LI | S_EI | S_LA | S_LB | S_LO;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [5:0] st_drv = 6'b000001;
  logic [3:0] op_drv = 4'b0000;

  always #5 CLK = ~CLK;

  control_sequencer_if #(.ICOUNT_W(8)) bus ();
  control_sequencer_if #(.ICOUNT_W(2)) bus2 ();

  assign bus.state   = st_drv;
  assign bus.opcode  = op_drv;
  assign bus2.state  = st_drv;
  assign bus2.opcode = op_drv;

  control_sequencer #(.ICOUNT_W(8)) dut  (.CLK(CLK), .CLR(CLR), .bus(bus));
  control_sequencer #(.ICOUNT_W(2)) dut2 (.CLK(CLK), .CLR(CLR), .bus(bus2));

  int errs   = 0;
  int checks = 0;

  // Reference model state
  bit m_hlt, m_ill, m_err;
  int m_cnt, m_pos;

  typedef struct {
    string       name;
    logic [5:0]  st;
    logic [3:0]  op;
    logic [11:0] con;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit op_defined(input logic [3:0] op);
    return op == 4'd0 || op == 4'd1 || op == 4'd2 || op == 4'd14 || op == 4'd15;
  endfunction

  function automatic logic [11:0] model_con(input logic [5:0] st, input logic [3:0] op,
                                            input bit halted);
    logic [11:0] act;
    int t;
    act = '0;
    t = 0;
    if ($countones(st) == 1)
      for (int i = 0; i < 6; i++) if (st[i]) t = i + 1;
    if (!halted) begin
      case (t)
        1: act = S_EP | S_LM;
        2: act = S_CP;
        3: act = S_CE | S_LI;
        4: if (op == 4'd0 || op == 4'd1 || op == 4'd2) act = S_LM | S_EI;
           else if (op == 4'd14) act = S_EA | S_LO;
        5: if (op == 4'd0) act = S_CE | S_LA;
           else if (op == 4'd1 || op == 4'd2) act = S_CE | S_LB;
        6: if (op == 4'd1) act = S_LA | S_EU;
           else if (op == 4'd2) act = S_LA | S_SU | S_EU;
        default: act = '0;
      endcase
    end
    return act ^ ACTIVE_LOW;
  endfunction

  task automatic model_edge(input logic [5:0] st, input logic [3:0] op);
    logic [5:0] e;
    e = 6'b000001 << m_pos;
    if (st == 6'b001000 && op == 4'd15) m_hlt = 1'b1;
    else if (st == 6'b001000 && !op_defined(op) && !m_hlt) m_ill = 1'b1;
    if (st == 6'b100000 && !m_hlt) m_cnt++;
    if (st != e) m_err = 1'b1;
    m_pos = (m_pos + 1) % 6;
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_hlt"},      32'(bus.hlt),        32'(m_hlt));
    chk({tag, "_illegal"},  32'(bus.illegal_op), 32'(m_ill));
    chk({tag, "_icount"},   32'(bus.icount),     32'(m_cnt % 256));
    chk({tag, "_icount2"},  32'(bus2.icount),    32'(m_cnt % 4));
    chk({tag, "_seq_err"},  32'(bus.seq_err),    32'(CHK ? m_err : 1'b0));
  endtask

  task automatic step(input logic [5:0] st, input logic [3:0] op);
    st_drv = st;
    op_drv = op;
    #1;
    chk("con", 32'(bus.con), 32'(model_con(st, op, m_hlt)));
    @(posedge CLK);
    model_edge(st, op);
    #1;
    check_regs("step");
  endtask

  task automatic do_clr();
    CLR = 1'b1;
    st_drv = 6'b000001;
    op_drv = 4'd0;
    #1;
    m_hlt = 0; m_ill = 0; m_err = 0; m_cnt = 0; m_pos = 0;
    check_regs("clr");
    chk("clr_con", 32'(bus.con), 32'h5E3);
    CLR = 1'b0;
    #1;
  endtask

  task automatic instr(input logic [3:0] op);
    for (int t = 0; t < 6; t++) step(6'b000001 << t, op);
  endtask

  initial begin
    vecs.push_back('{"lda_t1", 6'b000001, 4'd0,  12'h5E3});
    vecs.push_back('{"lda_t2", 6'b000010, 4'd0,  12'hBE3});
    vecs.push_back('{"lda_t3", 6'b000100, 4'd0,  12'h263});
    vecs.push_back('{"lda_t4", 6'b001000, 4'd0,  12'h1A3});
    vecs.push_back('{"lda_t5", 6'b010000, 4'd0,  12'h2C3});
    vecs.push_back('{"lda_t6", 6'b100000, 4'd0,  12'h3E3});
    vecs.push_back('{"add_t5", 6'b010000, 4'd1,  12'h2E1});
    vecs.push_back('{"add_t6", 6'b100000, 4'd1,  12'h3C7});
    vecs.push_back('{"sub_t4", 6'b001000, 4'd2,  12'h1A3});
    vecs.push_back('{"sub_t6", 6'b100000, 4'd2,  12'h3CF});
    vecs.push_back('{"out_t4", 6'b001000, 4'd14, 12'h3F2});
    vecs.push_back('{"out_t5", 6'b010000, 4'd14, 12'h3E3});
    vecs.push_back('{"udf_t4", 6'b001000, 4'd5,  12'h3E3});
    vecs.push_back('{"two_hot", 6'b000011, 4'd0, 12'h3E3});
    vecs.push_back('{"zero_st", 6'b000000, 4'd1, 12'h3E3});
    vecs.push_back('{"hlt_t4", 6'b001000, 4'd15, 12'h3E3});

    do_clr();

    foreach (vecs[i]) begin
      st_drv = vecs[i].st;
      op_drv = vecs[i].op;
      #1;
      chk(vecs[i].name, 32'(bus.con), 32'(vecs[i].con));
      step(vecs[i].st, vecs[i].op);
    end

    // LDA through a full ring
    do_clr();
    instr(4'd0);
    chk("lda_icount", 32'(bus.icount), 32'd1);
    chk("lda_illegal", 32'(bus.illegal_op), 32'd0);

    // ADD then SUB
    do_clr();
    instr(4'd1);
    instr(4'd2);
    chk("addsub_icount", 32'(bus.icount), 32'd2);

    // OUT then HLT, ring keeps running with LDA opcode
    do_clr();
    instr(4'd14);
    instr(4'd15);
    instr(4'd0);
    instr(4'd0);
    chk("halt_hlt", 32'(bus.hlt), 32'd1);
    chk("halt_icount", 32'(bus.icount), 32'd1);
    do_clr();
    chk("halt_cleared", 32'(bus.hlt), 32'd0);

    // Undefined opcode still retires
    do_clr();
    instr(4'd5);
    chk("udf_illegal", 32'(bus.illegal_op), 32'd1);
    chk("udf_icount", 32'(bus.icount), 32'd1);

    // Ring skip T3: checker flags and holds
    do_clr();
    step(6'b000001, 4'd0);
    step(6'b000010, 4'd0);
    step(6'b001000, 4'd0);
    chk("skip_seq_err", 32'(bus.seq_err), 32'(CHK));
    instr(4'd0);
    chk("skip_sticky", 32'(bus.seq_err), 32'(CHK));
    do_clr();
    chk("skip_cleared", 32'(bus.seq_err), 32'd0);

    // 2-bit counter wrap after 5 retirements
    do_clr();
    for (int k = 0; k < 5; k++) instr(4'd0);
    chk("wrap_icount2", 32'(bus2.icount), 32'd1);
    chk("wrap_icount", 32'(bus.icount), 32'd5);

    // Randomized traffic with occasional bad states and mid-instruction clears
    do_clr();
    for (int n = 0; n < 250; n++) begin
      logic [3:0] op;
      int r;
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: op = 4'd0;
        3:       op = 4'd1;
        4:       op = 4'd2;
        5:       op = 4'd14;
        6:       op = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'd1;
        default: op = 4'($urandom_range(0, 15));
      endcase
      for (int t = 0; t < 6; t++) begin
        logic [5:0] st;
        st = 6'b000001 << t;
        if ($urandom_range(0, 39) == 0) st = 6'($urandom);
        step(st, op);
        if ($urandom_range(0, 59) == 0) begin
          do_clr();
          break;
        end
      end
      if (m_hlt && $urandom_range(0, 2) == 0) do_clr();
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

SAP-1 controller-sequencer; the stage directly downstream of the ring counter. Consumes the one-hot T-state (T1..T6) and the 4-bit opcode from the instruction register, and drives the 12-bit SAP-1 control word to the datapath. Holds the halt latch, an illegal-opcode flag, a retired-instruction counter and an optional ring-sequence checker.

## Interface
- ICOUNT_W, 8, width of retired-instruction counter
- CLK  in  1  system clock; all state updates on rising edge
- CLR  in  1  asynchronous, active-high reset
- state  in  6  one-hot T-state from ring counter; bit0=T1 .. bit5=T6
- opcode  in  4  upper nibble of instruction register
- con  out  12  control word {Cp,Ep,Lm_bar,CE_bar,Li_bar,Ei_bar,La_bar,Ea,Su,Eu,Lb_bar,Lo_bar}, bit11..bit0
- hlt  out  1  halt latch; high = machine stopped, usable as clock-enable inhibit
- illegal_op  out  1  sticky: undefined opcode reached T4
- seq_err  out  1  sticky: ring-sequence violation (checker build only)
- icount  out  ICOUNT_W  retired-instruction count

## Operation
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111; all others undefined.
- con is combinational from state, opcode, hlt. NOP word = 12'h3E3.
- Fetch (all opcodes): T1=5E3, T2=BE3, T3=263.
- LDA: T4=1A3, T5=2C3, T6=3E3. ADD: T4=1A3, T5=2E1, T6=3C7. SUB: T4=1A3, T5=2E1, T6=3CF. OUT: T4=3F2, T5=3E3, T6=3E3. HLT and undefined: T4..T6=3E3.
- state not exactly one-hot (zero or multiple bits) -> con=3E3.
- hlt=1 -> con=3E3 regardless of state/opcode.
- Halt latch: set on rising edge with state=T4 and opcode=HLT; held until CLR. No other clear path.
- illegal_op: set on rising edge with state=T4, opcode undefined, hlt=0; held until CLR. Instruction otherwise executes as NOP.
- icount: +1 on rising edge with state=T6 and hlt=0; wraps modulo 2^ICOUNT_W. HLT instruction never retires (halts at T4).
- Checker (macro present): internal 6-bit expected register, reset to 6'b000001. Every rising edge: if state != expected, set seq_err (sticky until CLR); expected <= rotate-left(expected) (T6 -> T1). Expected advances independent of mismatch; checker runs while halted.

## Timing
- Reset values (async, CLR=1): hlt=0, illegal_op=0, seq_err=0, icount=0, expected=T1. con follows inputs combinationally; with hlt=0 and state=T1 it reads 5E3.
- CLR deassertion: first rising edge after release is treated as T1 by the checker; ring counter must be released on the same edge.
- con latency: zero cycles from state/opcode change.
- hlt: rises one cycle after the HLT T4 edge, i.e. during T5 of the HLT instruction; con already NOP during T4 by decode.
- icount updates at the end of T6 (visible during the following T1).
- Simultaneous: T4 with HLT opcode and an undefined-opcode check are mutually exclusive; seq_err and hlt may set on the same edge independently.
- CLR mid-instruction: all registers clear immediately, no partial-instruction retirement.

## Configuration
- CTRL_SEQ_CHECK_EN defined: expected register and seq_err logic present as above.
- Not defined: no expected register; seq_err tied to 0; all other behaviour unchanged (non-one-hot state still decodes to NOP).

## Test plan
- CLR pulse, then state T1..T6 with opcode=LDA -> con 5E3,BE3,263,1A3,2C3,3E3; icount=1 after T6 edge; all flags 0.
- ADD then SUB full cycles -> T5=2E1 both; T6=3C7 then 3CF; icount=2.
- OUT then HLT: OUT T4=3F2; HLT T4 con=3E3, hlt=1 from T5, con stays 3E3 across further ring cycles with opcode=LDA; icount frozen at 1; CLR restores hlt=0, icount=0.
- Opcode 0101 through T4 -> illegal_op=1 from next cycle, con 3E3 at T4..T6, icount still increments at T6.
- Checker build: drive T1,T2,T4 -> seq_err=1 after T4 edge, stays 1 through correct cycles until CLR; non-checker build same stimulus -> seq_err=0.
- state=6'b000011 and 6'b000000 -> con=3E3; ICOUNT_W=2 with 5 retirements -> icount=1 (wrap).
